// File: rtl/gf32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gf32_pkg
// Description : Shared constants and FSM state type for the GF(2^32)
//               sequential reduction block.
// Revision    : 1.0 - initial release
// ============================================================================
package gf32_pkg;

    localparam logic [31:0] POLY_LOW_DEFAULT = 32'h0000_008D;

    localparam int c_FOLDS_SERIAL = 32;
    localparam int c_FOLDS_FOLD4  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf32_state_e;

endpackage
`default_nettype wire

// File: rtl/gf32_fold_step.sv
`default_nettype none
// ============================================================================
// Module      : gf32_fold_step
// Description : Combinational single-bit fold: if w[i] is set, clear it and
//               XOR POLY_LOW into w[i-1:i-32]. Valid for i in 32..63.
// Revision    : 1.0 - initial release
// ============================================================================
module gf32_fold_step
    import gf32_pkg::*;
#(
    parameter logic [31:0] POLY_LOW = POLY_LOW_DEFAULT
) (
    input  logic [63:0] i_w,
    input  logic [5:0]  i_idx,
    output logic [63:0] o_w
);

    logic [63:0] w_mask;

    // For i >= 32 the low five index bits equal i-32, the target offset.
    always_comb begin
        w_mask = ({32'd0, POLY_LOW} << i_idx[4:0]) | (64'd1 << i_idx);
        o_w    = i_w[i_idx] ? (i_w ^ w_mask) : i_w;
    end

endmodule
`default_nettype wire

// File: rtl/gf32_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module      : gf32_reduce_seq
// Description : Sequential constant-time reduction of a 64-bit carry-less
//               product modulo x^32 + POLY_LOW. Define GF32_REDUCE_FOLD4_EN
//               to fold four bits per cycle instead of one.
// Revision    : 1.0 - initial release
// ============================================================================
module gf32_reduce_seq
    import gf32_pkg::*;
#(
    parameter logic [31:0] POLY_LOW = POLY_LOW_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] prod_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rem_out,
    output logic        busy
);

`ifdef GF32_REDUCE_FOLD4_EN
    localparam int c_FOLDS = c_FOLDS_FOLD4;
`else
    localparam int c_FOLDS = c_FOLDS_SERIAL;
`endif
    localparam int c_STEP  = 32 / c_FOLDS;
    localparam int c_CNT_W = $clog2(c_FOLDS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_FOLDS - 1);

    gf32_state_e        r_state_q,     w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,       w_cnt_d;
    logic [63:0]        r_work_q,      w_work_d;
    logic               r_in_ready_q,  w_in_ready_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic               r_busy_q,      w_busy_d;
    logic [31:0]        r_rem_q,       w_rem_d;

    logic [c_STEP:0][63:0] w_chain;

    assign w_chain[0] = r_work_q;

    // Each cycle folds c_STEP bits, most significant unprocessed bit first.
    generate
        for (genvar k = 0; k < c_STEP; k++) begin : g_fold
            logic [5:0] w_idx;
            assign w_idx = 6'd63 - (6'(r_cnt_q) * 6'(c_STEP)) - 6'(k);
            gf32_fold_step #(
                .POLY_LOW (POLY_LOW)
            ) u_fold_step (
                .i_w   (w_chain[k]),
                .i_idx (w_idx),
                .o_w   (w_chain[k+1])
            );
        end
    endgenerate

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_work_d      = r_work_q;
        w_in_ready_d  = r_in_ready_q;
        w_out_valid_d = r_out_valid_q;
        w_busy_d      = r_busy_q;
        w_rem_d       = r_rem_q;
        case (r_state_q)
            IDLE: begin
                if (in_valid) begin
                    w_state_d    = BUSY;
                    w_work_d     = prod_in;
                    w_cnt_d      = '0;
                    w_in_ready_d = 1'b0;
                    w_busy_d     = 1'b1;
                end
            end
            BUSY: begin
                w_work_d = w_chain[c_STEP];
                w_cnt_d  = r_cnt_q + 1'b1;
                if (r_cnt_q == c_LAST) begin
                    w_state_d     = DONE;
                    w_cnt_d       = '0;
                    w_busy_d      = 1'b0;
                    w_out_valid_d = 1'b1;
                    w_rem_d       = w_chain[c_STEP][31:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_d     = IDLE;
                    w_out_valid_d = 1'b0;
                    w_in_ready_d  = 1'b1;
                end
            end
            default: begin
                w_state_d     = IDLE;
                w_cnt_d       = '0;
                w_in_ready_d  = 1'b1;
                w_out_valid_d = 1'b0;
                w_busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_cnt_q       <= '0;
            r_work_q      <= '0;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_rem_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_work_q      <= w_work_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
            r_busy_q      <= w_busy_d;
            r_rem_q       <= w_rem_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign busy      = r_busy_q;
    assign rem_out   = r_rem_q;

endmodule
`default_nettype wire

// File: tb/tb_gf32_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf32_reduce_seq
// Description : Self-checking scoreboard bench for gf32_reduce_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf32_reduce_seq;

`ifdef GF32_REDUCE_FOLD4_EN
    localparam int c_LAT = 8;
`else
    localparam int c_LAT = 32;
`endif
    localparam int          c_II   = c_LAT + 2;
    localparam logic [32:0] c_POLY = 33'h1_0000_008D;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] prod_in;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] rem_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    logic [31:0] exp_q[$];

    gf32_reduce_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod_in   (prod_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rem_out   (rem_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Polynomial long division by the full degree-32 modulus.
    function automatic logic [31:0] gf_ref(input logic [63:0] p);
        logic [63:0] r;
        r = p;
        for (int i = 63; i >= 32; i--) begin
            if (r[i]) r = r ^ ({31'd0, c_POLY} << (i - 32));
        end
        return r[31:0];
    endfunction

    // Called at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [63:0] p, input logic [31:0] exp,
                        input bit junk, output int acc_cycle);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_in_ready: got %b want 1 after %0d cycles", in_ready, guard);
        end
        in_valid = 1'b1;
        prod_in  = p;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        acc_cycle = cycle;
        in_valid  = junk;
        prod_in   = junk ? {$urandom(), $urandom()} : 64'd0;
    endtask

    task automatic wait_out(output logic [31:0] rem, output int lat,
                            output bit busy_ok, output bit to);
        bit done;
        lat = 0; busy_ok = 1'b1; to = 1'b0; done = 1'b0;
        while (!done) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) done = 1'b1;
            else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (lat >= 200) begin
                    to = 1'b1;
                    done = 1'b1;
                end
            end
        end
        rem = rem_out;
    endtask

    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; prod_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (rem_out !== 32'd0) begin n_fail++; $display("FAIL reset_rem_out: got %h want 0", rem_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [63:0] vp [4];
        logic [31:0] ve [4];
        logic [31:0] rem, exp;
        int lat, acc;
        bit bok, to;
        vp[0] = 64'h0000_0001_0000_0000; ve[0] = 32'h0000_008D;
        vp[1] = 64'h0000_0000_1234_5678; ve[1] = 32'h1234_5678;
        vp[2] = 64'h8000_0000_0000_0000; ve[2] = 32'h8000_206E;
        vp[3] = 64'h0000_0000_0000_0000; ve[3] = 32'h0000_0000;
        for (int v = 0; v < 4; v++) begin
            send(vp[v], ve[v], 1'b0, acc);
            wait_out(rem, lat, bok, to);
            exp = exp_q.pop_front();
            n_checks++;
            if (to || rem !== exp) begin
                n_fail++;
                $display("FAIL directed_rem[%0d]: got %h want %h (timeout=%0b)", v, rem, exp, to);
            end
            n_checks++;
            if (lat != c_LAT) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", v, lat, c_LAT); end
            n_checks++;
            if (!bok) begin n_fail++; $display("FAIL directed_busy[%0d]: busy got 0 want 1 while folding", v); end
            release_out();
        end
    endtask

    // Output held with out_ready low while in_valid and prod_in toggle.
    task automatic test_stall();
        logic [63:0] p;
        logic [31:0] rem, exp;
        int lat, acc;
        bit bok, to;
        p = {$urandom(), $urandom()};
        send(p, gf_ref(p), 1'b1, acc);
        wait_out(rem, lat, bok, to);
        exp = exp_q.pop_front();
        n_checks++;
        if (to || rem !== exp) begin n_fail++; $display("FAIL stall_rem: got %h want %h", rem, exp); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            prod_in = {$urandom(), $urandom()};
            n_checks++;
            if (out_valid !== 1'b1 || rem_out !== exp || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b rem=%h rdy=%b want v=1 rem=%h rdy=0",
                         c, out_valid, rem_out, in_ready, exp);
            end
        end
        release_out();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midbusy();
        logic [63:0] p;
        logic [31:0] rem, exp;
        int lat, acc;
        bit bok, to, seen;
        p = 64'hDEAD_BEEF_0123_4567;
        send(p, gf_ref(p), 1'b0, acc);
        void'(exp_q.pop_back());
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || rem_out !== 32'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midbusy_reset: got rdy=%b v=%b rem=%h busy=%b want 1 0 0 0",
                     in_ready, out_valid, rem_out, busy);
        end
        seen = 1'b0;
        for (int c = 0; c < c_LAT + 5; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midbusy_no_pulse: got out_valid=1 want 0"); end
        p = 64'h0F0F_F0F0_A5A5_5A5A;
        send(p, gf_ref(p), 1'b0, acc);
        wait_out(rem, lat, bok, to);
        exp = exp_q.pop_front();
        n_checks++;
        if (to || rem !== exp) begin n_fail++; $display("FAIL midbusy_next: got %h want %h", rem, exp); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [63:0] p;
        logic [31:0] rem, exp;
        int lat, acc, prev;
        bit bok, to;
        prev = 0;
        for (int n = 0; n < 1000; n++) begin
            p = {$urandom(), $urandom()};
            if (n % 10 == 0) p[63:32] = 32'd0;
            send(p, gf_ref(p), (n % 7 == 0), acc);
            if (n > 0 && n < 20) begin
                n_checks++;
                if (acc - prev != c_II) begin
                    n_fail++;
                    $display("FAIL b2b_interval[%0d]: got %0d want %0d", n, acc - prev, c_II);
                end
            end
            wait_out(rem, lat, bok, to);
            exp = exp_q.pop_front();
            n_checks++;
            if (to || rem !== exp) begin
                n_fail++;
                $display("FAIL b2b_rem[%0d]: prod=%h got %h want %h", n, p, rem, exp);
            end
            release_out();
            prev = acc;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_midbusy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gf32_reduce_seq.md
GF32_REDUCE_SEQ -- requirements
Module: gf32_reduce_seq

Interface
REQ-001 The module SHALL have parameter POLY_LOW, default 32'h0000_008D, giving the low 32 coefficients of the monic degree-32 reduction polynomial (default x^32+x^7+x^3+x^2+1).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: prod_in is valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block can accept an input.
REQ-006 The module SHALL have port prod_in, input, 64 bits: carry-less product from the upstream 32x32 GF(2) Karatsuba multiplier.
REQ-007 The module SHALL have port out_valid, output, 1 bit: rem_out is valid.
REQ-008 The module SHALL have port out_ready, input, 1 bit: the downstream stage accepts rem_out.
REQ-009 The module SHALL have port rem_out, output, 32 bits: prod_in mod (x^32 + POLY_LOW), GF(2) arithmetic.
REQ-010 The module SHALL have port busy, output, 1 bit: high in the BUSY state.

Function
REQ-011 The module SHALL be a three-state FSM: IDLE (in_ready=1), BUSY (folding), DONE (out_valid=1).
REQ-012 In IDLE, an edge with in_valid=1 SHALL latch prod_in into a 64-bit working register, clear the fold counter, and move to BUSY; in_valid=0 SHALL leave it in IDLE.
REQ-013 Each BUSY edge SHALL fold the current top unprocessed bit i (63 down to 32): if w[i]=1, clear w[i] and XOR POLY_LOW into w[i-1:i-32]; all arithmetic is XOR, with no carries.
REQ-014 Bit-serial mode SHALL use 32 folds; out_valid SHALL assert exactly 32 cycles after the accepting edge.
REQ-015 On entering DONE, rem_out SHALL equal w[31:0], and rem_out and out_valid SHALL hold stable until an edge with out_ready=1.
REQ-016 A DONE edge with out_ready=1 SHALL return the FSM to IDLE; the block accepts no new input in that same cycle, so the minimum initiation interval is 34 cycles (10 cycles with the macro).
REQ-017 in_valid SHALL be ignored outside IDLE; prod_in changes during BUSY or DONE SHALL NOT affect the result.
REQ-018 A zero prod_in SHALL still take the full fold latency; the latency SHALL be data-independent for constant-time cryptographic use.
REQ-019 An input with prod_in[63:32]=0 SHALL give rem_out = prod_in[31:0].

Reset
REQ-020 On an edge with rst=1, the FSM SHALL go to IDLE, the counter and working register SHALL clear, and the outputs SHALL be in_ready=1, out_valid=0, busy=0, rem_out=0.
REQ-021 Reset SHALL override any in-flight operation in BUSY or DONE; the partial result is discarded and no out_valid pulse follows.
REQ-022 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-023 Macro GF32_REDUCE_FOLD4_EN, when defined, SHALL make each BUSY edge fold four bits, MSB first (i, i-1, i-2, i-3), giving 8 folds and out_valid 8 cycles after acceptance.
REQ-024 When GF32_REDUCE_FOLD4_EN is undefined, the bit-serial behaviour of REQ-014 applies; rem_out values SHALL be identical in both builds.

Structure
REQ-025 A shared package gf32_pkg SHALL hold POLY_LOW_DEFAULT (32'h0000_008D), the FSM state typedef (IDLE/BUSY/DONE), and the fold-count constants (32 and 8).
REQ-026 The module SHALL contain one sub-module, gf32_fold_step: a combinational single-bit fold (64-bit in, bit index, 64-bit out), instantiated once (serial) or chained four times (FOLD4).

Verification
REQ-027 The bench SHALL check: prod_in=64'h0000_0001_0000_0000 -> rem_out=32'h0000_008D, with out_valid after 32 cycles (8 with FOLD4).
REQ-028 The bench SHALL check: prod_in=64'h0000_0000_1234_5678 -> rem_out=32'h1234_5678, with the same latency as REQ-027.
REQ-029 The bench SHALL check: prod_in=64'h8000_0000_0000_0000 -> rem_out=32'h8000_206E.
REQ-030 The bench SHALL check: out_ready held low 10 cycles in DONE -> rem_out and out_valid stable and in_ready=0 throughout; in_ready=1 the cycle after out_ready rises.
REQ-031 The bench SHALL check: rst pulsed at BUSY fold 5 -> in_ready=1, out_valid=0, and rem_out=0 on the next cycle; the next accepted input reduces correctly.
REQ-032 The bench SHALL run 1000 random products in both builds -> every rem_out matches a software GF(2) reference model.
